// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner and fetch controller for a 1-cycle registered instruction memory.
// Ports:
//   clk, reset                 clock and asynchronous active-high reset
//   imem_addr / imem_instr     registered fetch address out, previous-cycle word in
//   out_valid/ready/instr/pc   2-entry first-word-fall-through queue toward decode
//   redirect_valid/pc          one-cycle redirect (flushes queue and in-flight word)
//   halt_req / halted          level halt request and halted status
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt_req,
   output logic        halted
);
   localparam logic [31:0] ADDR_MASK = 32'(IMEM_WORDS * 4 - 1) & 32'hFFFF_FFFC;
   typedef enum logic [1:0] {BOOT, RUN, DRAIN, HALTED} state_t;
   state_t      r_state;
   logic [31:0] r_fetch_pc, r_inflight_pc, r_head_instr, r_head_pc, r_tail_instr, r_tail_pc;
   logic        r_inflight_valid, r_halted;
   logic [1:0]  r_count;
   logic        w_pop, w_push, w_issue, w_empty;
   logic [1:0]  w_rem;
   assign w_pop   = (r_count != 2'd0) & out_ready;
   assign w_rem   = r_count - {1'b0, w_pop};
   assign w_push  = r_inflight_valid & ~redirect_valid;
   assign w_empty = (r_count == 2'd0) & ~r_inflight_valid;
   // Reserve a slot for the word already in flight so the queue never overflows.
   assign w_issue = (r_state == RUN) & ~redirect_valid & ~halt_req &
                    ((w_rem + {1'b0, r_inflight_valid}) < 2'd2);
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state          <= BOOT;
         r_fetch_pc       <= RESET_PC & 32'hFFFF_FFFC;
         r_inflight_pc    <= '0;
         r_inflight_valid <= 1'b0;
         r_head_instr     <= '0;
         r_head_pc        <= '0;
         r_tail_instr     <= '0;
         r_tail_pc        <= '0;
         r_count          <= '0;
         r_halted         <= 1'b0;
      end else begin
         r_inflight_valid <= w_issue;
         if (w_issue) r_inflight_pc <= r_fetch_pc;
         if (redirect_valid) r_fetch_pc <= redirect_pc & ADDR_MASK;
         else if (w_issue) r_fetch_pc <= (r_fetch_pc + 32'd4) & ADDR_MASK;
         r_count <= redirect_valid ? 2'd0 : w_rem + {1'b0, w_push};
         // Queue is a 2-deep shift: head feeds the outputs directly and keeps its
         // value when emptied, which gives hold-last-value behaviour for free.
         if (w_push && w_rem == 2'd0) begin
            r_head_instr <= imem_instr;
            r_head_pc    <= r_inflight_pc;
         end else if (w_pop && r_count == 2'd2 && !redirect_valid) begin
            r_head_instr <= r_tail_instr;
            r_head_pc    <= r_tail_pc;
         end
         if (w_push && w_rem == 2'd1) begin
            r_tail_instr <= imem_instr;
            r_tail_pc    <= r_inflight_pc;
         end
         if (redirect_valid) begin
            r_state  <= RUN;
            r_halted <= 1'b0;
         end else begin
            case (r_state)
               BOOT: begin
                  r_state  <= halt_req ? HALTED : RUN;
                  r_halted <= halt_req;
               end
               RUN: r_state <= halt_req ? DRAIN : RUN;
               DRAIN: begin
                  r_state  <= !halt_req ? RUN : w_empty ? HALTED : DRAIN;
                  r_halted <= halt_req & w_empty;
               end
               default: begin
                  r_state  <= halt_req ? HALTED : RUN;
                  r_halted <= halt_req;
               end
            endcase
         end
      end
   end
   assign imem_addr = r_fetch_pc;
   assign out_valid = r_count != 2'd0;
   assign out_instr = r_head_instr;
   assign out_pc    = r_head_pc;
   assign halted    = r_halted;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed self-checking bench for fetch_sequencer.
module tb_fetch_sequencer;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] imem_addr, imem_instr, out_instr, out_pc, redirect_pc;
   logic        out_valid, out_ready, redirect_valid, halt_req, halted;
   logic [31:0] mem [0:1023];
   int          passed = 0;
   int          total = 0;
   localparam logic [31:0] I_ADD = 32'h0020_81B3;
   localparam logic [31:0] I_SUB = 32'h4020_8233;
   localparam logic [31:0] I_MUL = 32'h0220_82B3;
   localparam logic [31:0] I_AND = 32'h0020_F333;
   localparam logic [31:0] I_LW  = 32'h0002_A383;
   localparam logic [31:0] I_BEQ = 32'h0020_8463;
   fetch_sequencer dut (
      .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .halt_req(halt_req), .halted(halted)
   );
   always #5 clk = ~clk;
   always_ff @(posedge clk) imem_instr <= mem[imem_addr[11:2]];
   function automatic logic [31:0] filler(input int idx);
      return {16'hC0DE, 4'h0, 12'(idx)};
   endfunction
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   // Releases reset before the next edge and steps to the first valid word (3 edges).
   task automatic start();
      reset = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      halt_req = 1'b0;
      out_ready = 1'b1;
      #2;
      reset = 1'b0;
      repeat (3) step();
   endtask
   task automatic test_reset();
      #1;
      total++; if (imem_addr !== 32'h0) $display("FAIL rst_addr got=%h exp=%h", imem_addr, 32'h0); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", out_valid); else passed++;
      total++; if (out_instr !== 32'h0 || out_pc !== 32'h0) $display("FAIL rst_out got=%h/%h exp=0/0", out_instr, out_pc); else passed++;
      total++; if (halted !== 1'b0) $display("FAIL rst_halted got=%b exp=0", halted); else passed++;
   endtask
   task automatic test_stream();
      logic [31:0] exp_i [4];
      exp_i = '{I_ADD, I_SUB, I_MUL, I_AND};
      reset = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      halt_req = 1'b0;
      out_ready = 1'b1;
      #2;
      reset = 1'b0;
      for (int c = 1; c <= 2; c++) begin
         step();
         total++; if (out_valid !== 1'b0) $display("FAIL stream_early_valid c=%0d got=%b exp=0", c, out_valid); else passed++;
      end
      for (int k = 0; k < 4; k++) begin
         step();
         total++;
         if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_instr !== exp_i[k])
            $display("FAIL stream_%0d got=%b/%h/%h exp=1/%h/%h", k, out_valid, out_pc, out_instr, 32'(4 * k), exp_i[k]);
         else passed++;
      end
   endtask
   task automatic test_backpressure();
      start();
      step();
      total++; if (out_pc !== 32'h4) $display("FAIL bp_first got=%h exp=%h", out_pc, 32'h4); else passed++;
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (c > 0) step();
         total++;
         if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_instr !== I_SUB)
            $display("FAIL bp_hold c=%0d got=%b/%h/%h exp=1/%h/%h", c, out_valid, out_pc, out_instr, 32'h4, I_SUB);
         else passed++;
      end
      step();
      out_ready = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         if (k > 1) step();
         total++;
         if (out_valid !== 1'b1 || out_pc !== 32'(4 * k))
            $display("FAIL bp_release_%0d got=%b/%h exp=1/%h", k, out_valid, out_pc, 32'(4 * k));
         else passed++;
      end
      step();
      total++; if (out_pc !== 32'h10 || out_instr !== filler(4)) $display("FAIL bp_next got=%h/%h exp=%h/%h", out_pc, out_instr, 32'h10, filler(4)); else passed++;
   endtask
   task automatic test_redirect();
      start();
      out_ready = 1'b0;
      step();
      total++; if (out_valid !== 1'b1 || out_pc !== 32'h0) $display("FAIL rd_pre got=%b/%h exp=1/%h", out_valid, out_pc, 32'h0); else passed++;
      redirect_valid = 1'b1;
      redirect_pc = 32'h43;
      out_ready = 1'b1;
      step();
      redirect_valid = 1'b0;
      total++; if (out_valid !== 1'b0) $display("FAIL rd_flush got=%b exp=0", out_valid); else passed++;
      total++; if (imem_addr !== 32'h40) $display("FAIL rd_addr got=%h exp=%h", imem_addr, 32'h40); else passed++;
      step();
      total++; if (out_valid !== 1'b0) $display("FAIL rd_gap got=%b exp=0", out_valid); else passed++;
      step();
      total++; if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== I_BEQ) $display("FAIL rd_first got=%b/%h/%h exp=1/%h/%h", out_valid, out_pc, out_instr, 32'h40, I_BEQ); else passed++;
      step();
      total++; if (out_pc !== 32'h44 || out_instr !== filler(17)) $display("FAIL rd_second got=%h/%h exp=%h/%h", out_pc, out_instr, 32'h44, filler(17)); else passed++;
   endtask
   task automatic test_halt();
      start();
      halt_req = 1'b1;
      step();
      total++; if (out_valid !== 1'b1 || out_pc !== 32'h4) $display("FAIL halt_drain got=%b/%h exp=1/%h", out_valid, out_pc, 32'h4); else passed++;
      step();
      total++; if (out_valid !== 1'b0 || halted !== 1'b0) $display("FAIL halt_empty got=%b/%b exp=0/0", out_valid, halted); else passed++;
      for (int c = 0; c < 3; c++) begin
         step();
         total++; if (halted !== 1'b1 || out_valid !== 1'b0) $display("FAIL halt_hold c=%0d got=%b/%b exp=1/0", c, halted, out_valid); else passed++;
      end
      total++; if (imem_addr !== 32'h8) $display("FAIL halt_pc got=%h exp=%h", imem_addr, 32'h8); else passed++;
      redirect_valid = 1'b1;
      redirect_pc = 32'h38;
      halt_req = 1'b0;
      step();
      redirect_valid = 1'b0;
      total++; if (halted !== 1'b0) $display("FAIL halt_leave got=%b exp=0", halted); else passed++;
      step();
      step();
      total++; if (out_valid !== 1'b1 || out_pc !== 32'h38 || out_instr !== I_LW) $display("FAIL halt_resume got=%b/%h/%h exp=1/%h/%h", out_valid, out_pc, out_instr, 32'h38, I_LW); else passed++;
   endtask
   task automatic test_wrap();
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFC;
      step();
      redirect_valid = 1'b0;
      step();
      step();
      total++; if (out_valid !== 1'b1 || out_pc !== 32'hFFC || out_instr !== filler(1023)) $display("FAIL wrap_last got=%b/%h/%h exp=1/%h/%h", out_valid, out_pc, out_instr, 32'hFFC, filler(1023)); else passed++;
      step();
      total++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== I_ADD) $display("FAIL wrap_zero got=%b/%h/%h exp=1/%h/%h", out_valid, out_pc, out_instr, 32'h0, I_ADD); else passed++;
   endtask
   task automatic test_async_reset();
      start();
      out_ready = 1'b0;
      repeat (3) step();
      total++; if (out_valid !== 1'b1 || imem_addr !== 32'h8) $display("FAIL ar_pre got=%b/%h exp=1/%h", out_valid, imem_addr, 32'h8); else passed++;
      reset = 1'b1;
      #1;
      total++; if (out_valid !== 1'b0 || imem_addr !== 32'h0) $display("FAIL ar_immediate got=%b/%h exp=0/%h", out_valid, imem_addr, 32'h0); else passed++;
      out_ready = 1'b1;
      #1;
      reset = 1'b0;
      step();
      step();
      total++; if (out_valid !== 1'b0) $display("FAIL ar_gap got=%b exp=0", out_valid); else passed++;
      step();
      total++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== I_ADD) $display("FAIL ar_restart got=%b/%h/%h exp=1/%h/%h", out_valid, out_pc, out_instr, 32'h0, I_ADD); else passed++;
   endtask
   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = filler(i);
      mem[0]  = I_ADD;
      mem[1]  = I_SUB;
      mem[2]  = I_MUL;
      mem[3]  = I_AND;
      mem[14] = I_LW;
      mem[16] = I_BEQ;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      halt_req = 1'b0;
      out_ready = 1'b1;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_halt();
      test_wrap();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
